// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Decimal digits needed to show the largest unsigned value of `width` bits.
    function automatic int ceil_digits(input int width);
        longint unsigned maxv;
        int              n;
        maxv = (width >= 64) ? '1 : ((64'(1) << width) - 64'(1));
        n    = 1;
        while (maxv >= 64'(10)) begin
            maxv = maxv / 64'(10);
            n    = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bcd_seq_conv.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_BLANK_EN to add the registered leading-zero `blank` output.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]             blank
`endif
);

    localparam int SW    = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (DIGITS < ceil_digits(WIDTH)) begin : g_param_chk
        $error("bcd_seq_conv: DIGITS too small to hold 2**WIDTH-1");
    end

    bcd_state_t       state_q, state_d;
    logic [SW-1:0]    scratch_q, scratch_d, scratch_adj;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    bcd_q, bcd_d;
    logic             load_out;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scratch_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        load_out  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(WIDTH);
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                // The top scratch bit falls off; DIGITS is sized so it is always zero.
                {scratch_d, shift_d} = {scratch_adj[SW-2:0], shift_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                    bcd_d    = scratch_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign bcd  = bcd_q;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Ones digit is never blanked so a zero result still shows one "0".
    always_comb begin
        logic all_zero;
        blank_d  = blank_q;
        all_zero = 1'b1;
        if (load_out) begin
            blank_d = '0;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                all_zero   = all_zero & (scratch_d[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
                blank_d[k] = all_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_q <= ~DIGITS'(1);
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Scoreboard bench for bcd_seq_conv: default 12-bit/4-digit instance plus an 8-bit/3-digit one.
module tb_bcd_seq_conv;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  blank;
        int          cyc;
    } exp_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [11:0] bin    = '0;
    logic        busy, done;
    logic [15:0] bcd;
    logic        start8 = 1'b0;
    logic [7:0]  bin8   = '0;
    logic        busy8, done8;
    logic [11:0] bcd8;
`ifdef BCD_BLANK_EN
    logic [3:0]  blank;
    logic [2:0]  blank8;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    exp_t        q12[$];
    exp_t        q8[$];
    exp_t        e12, e8;
    logic [15:0] last12 = '0;
    logic [11:0] last8  = '0;

    bcd_seq_conv #(.WIDTH(12), .DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    bcd_seq_conv #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8)
`ifdef BCD_BLANK_EN
        ,
        .blank (blank8)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor for the 12-bit instance.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy_and_done12", {63'd0, busy & done}, 64'd0);
            if (done) begin
                if (q12.size() == 0) begin
                    chk("unexpected_done12", {63'd0, done}, 64'd0);
                end else begin
                    e12 = q12.pop_front();
                    chk("bcd12", {48'd0, bcd}, {48'd0, e12.bcd});
                    chk("done_cycle12", 64'(cyc), 64'(e12.cyc));
`ifdef BCD_BLANK_EN
                    chk("blank12", {60'd0, blank}, {60'd0, e12.blank});
`endif
                    last12 = e12.bcd;
                end
            end else if (bcd !== last12) begin
                chk("bcd12_stable", {48'd0, bcd}, {48'd0, last12});
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy_and_done8", {63'd0, busy8 & done8}, 64'd0);
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", {63'd0, done8}, 64'd0);
                end else begin
                    e8 = q8.pop_front();
                    chk("bcd8", {52'd0, bcd8}, {48'd0, e8.bcd});
                    chk("done_cycle8", 64'(cyc), 64'(e8.cyc));
`ifdef BCD_BLANK_EN
                    chk("blank8", {61'd0, blank8}, {60'd0, e8.blank});
`endif
                    last8 = e8.bcd[11:0];
                end
            end else if (bcd8 !== last8) begin
                chk("bcd8_stable", {52'd0, bcd8}, {52'd0, last8});
            end
        end
    end

    // Called at a negedge; the following posedge is the accepting edge when accepted=1.
    task automatic go12(input logic [11:0] v, input logic [15:0] eb, input logic [3:0] ebl,
                        input bit accepted);
        bin   = v;
        start = 1'b1;
        if (accepted) q12.push_back('{eb, ebl, cyc + 1 + 12});
        @(negedge clk);
        start = 1'b0;
        chk("busy12_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q12.size() != 0 || q8.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(q12.size() + q8.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int e;
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_bcd", {48'd0, bcd}, 64'd0);
        chk("reset_busy8", {63'd0, busy8}, 64'd0);
        chk("reset_bcd8", {52'd0, bcd8}, 64'd0);
`ifdef BCD_BLANK_EN
        chk("reset_blank", {60'd0, blank}, 64'b1110);
        chk("reset_blank8", {61'd0, blank8}, 64'b110);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        go12(12'd4095, 16'h4095, 4'b0000, 1'b1);
        drain();
        go12(12'd255, 16'h0255, 4'b1000, 1'b1);
        drain();
        go12(12'd0, 16'h0000, 4'b1110, 1'b1);
        drain();

        // A start in the middle of a conversion must be ignored.
        go12(12'd4095, 16'h4095, 4'b0000, 1'b1);
        repeat (4) @(negedge clk);
        go12(12'd100, 16'h0100, 4'b1100, 1'b0);
        drain();
        repeat (20) @(negedge clk);

        // Start held high: second operand is taken in the DONE cycle.
        bin   = 12'd1234;
        start = 1'b1;
        e     = cyc + 1;
        q12.push_back('{16'h1234, 4'b0000, e + 12});
        repeat (13) @(negedge clk);
        bin = 12'd987;
        q12.push_back('{16'h0987, 4'b1000, e + 13 + 12});
        @(negedge clk);
        start = 1'b0;
        bin   = 12'd555;
        drain();

        // Asynchronous reset in the middle of SHIFT.
        go12(12'd4095, 16'h4095, 4'b0000, 1'b1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        chk("midreset_bcd", {48'd0, bcd}, 64'd0);
`ifdef BCD_BLANK_EN
        chk("midreset_blank", {60'd0, blank}, 64'b1110);
`endif
        q12.delete();
        last12 = '0;
        last8  = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        go12(12'd255, 16'h0255, 4'b1000, 1'b1);
        drain();

        // Narrow instance: 8 bits into 3 digits.
        bin8   = 8'd200;
        start8 = 1'b1;
        q8.push_back('{16'h0200, 4'b0000, cyc + 1 + 8});
        @(negedge clk);
        start8 = 1'b0;
        chk("busy8_after_start", {63'd0, busy8}, 64'd1);
        drain();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
